// File: rtl/ram_pkg.sv
// Shared types and constants for the handshaked word memory (ram_ctrl).
package ram_pkg;

    // Largest wait-state count the 4-bit counter can hold.
    localparam int RAM_MAX_WAIT = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } ram_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } ram_op_t;

endpackage

// File: rtl/ram_array.sv
// Single-port word storage: synchronous read, lane-masked synchronous write.
// With LANES=1 and LANE_W=DATA_W it degenerates to a plain full-word RAM.
module ram_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 512,
    parameter int IDX_W  = 9,
    parameter int LANE_W = 8,
    parameter int LANES  = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [LANES-1:0]  lane_en,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write enabled lanes and register the addressed word every cycle.
    // NOTE: the storage array has no reset branch; clearing every word would
    // force it out of block RAM into flops, and its contents are undefined
    // after power-up anyway.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_en[i]) begin
                    mem_q[idx][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
                end
            end
        end
        rdata_q <= mem_q[idx];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ram_ctrl.sv
// Handshaked word memory for the mini CPU: read/write request, WAIT_CYCLES
// wait states, one-cycle ready pulse, out-of-range err flag and registered
// read data that holds between accesses.
// Optional feature: define RAM_BYTE_MASK_EN to add the byte_en port and
// byte-lane writes; left undefined, every write updates the whole word.
module ram_ctrl
    import ram_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int DEPTH       = 512,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                read,
    input  logic                write,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   BusMuxOut,
`ifdef RAM_BYTE_MASK_EN
    input  logic [DATA_W/8-1:0] byte_en,
`endif
    output logic [DATA_W-1:0]   BusMuxIn,
    output logic                ready,
    output logic                err
);

`ifdef RAM_BYTE_MASK_EN
    localparam int LANE_W = 8;
    localparam int LANES  = DATA_W / 8;
`else
    localparam int LANE_W = DATA_W;
    localparam int LANES  = 1;
`endif

    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]        WAIT_INIT = 4'(WAIT_CYCLES);
    // One extra bit so DEPTH = 2**ADDR_W is representable; compare is unsigned.
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > RAM_MAX_WAIT) begin : g_bad_wait
        $error("ram_ctrl: WAIT_CYCLES must be in 0..%0d", RAM_MAX_WAIT);
    end
    if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
        $error("ram_ctrl: DEPTH must be in 1..2**ADDR_W");
    end

    ram_state_t          state_q, state_d;
    logic [3:0]          cnt_q,   cnt_d;
    ram_op_t             op_q,    op_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [LANES-1:0]    ben_q,   ben_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ready_q, ready_d;
    logic                err_q,   err_d;

    logic                in_range;
    logic                commit;
    logic                arr_we;
    logic [IDX_W-1:0]    arr_idx;
    logic [DATA_W-1:0]   arr_rdata;

    assign in_range = ({1'b0, addr_q} < DEPTH_LIM);
    assign commit   = (state_q == BUSY) && (cnt_q == 4'd0);
    // Reset on the commit edge suppresses the write.
    assign arr_we   = commit && (op_q == OP_WRITE) && in_range && !reset;
    // The array is addressed by the incoming addr on the accept edge so the
    // word is already registered by the time a W=0 access commits.
    assign arr_idx  = (state_q == IDLE) ? addr[IDX_W-1:0] : addr_q[IDX_W-1:0];

    ram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .LANE_W (LANE_W),
        .LANES  (LANES)
    ) u_array (
        .clk     (clock),
        .we      (arr_we),
        .lane_en (ben_q),
        .idx     (arr_idx),
        .wdata   (wdata_q),
        .rdata   (arr_rdata)
    );

    // Next-state and next-output logic of the IDLE/BUSY/DONE access FSM.
    // NOTE: every _d gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ben_d   = ben_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (read || write) begin
                    op_d    = write ? OP_WRITE : OP_READ;
                    addr_d  = addr;
                    wdata_d = BusMuxOut;
`ifdef RAM_BYTE_MASK_EN
                    ben_d   = byte_en;
`else
                    ben_d   = '1;
`endif
                    cnt_d   = WAIT_INIT;
                    err_d   = 1'b0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    err_d   = !in_range;
                    if (op_q == OP_READ) begin
                        rdata_d = in_range ? arr_rdata : '0;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, request latches and registered outputs; synchronous reset.
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before the edge, regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            ben_q   <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ben_q   <= ben_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    assign BusMuxIn = rdata_q;
    assign ready    = ready_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Scoreboard bench for ram_ctrl: a driver issues accesses and pushes the
// expected completion (cycle, err, read data) computed from a word-level
// memory model; a negedge monitor pops and compares on every ready pulse.
module tb_ram_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 9;
    localparam int DEPTH  = 256;
    localparam int W      = 3;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        be;
    logic [31:0]       BusMuxIn;
    logic              ready;
    logic              err;

    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    exp_t        exp_q[$];
    logic [31:0] model_mem [int];
    logic [31:0] last_read = '0;

    ram_ctrl #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .read      (read),
        .write     (write),
        .addr      (addr),
        .BusMuxOut (wdata),
`ifdef RAM_BYTE_MASK_EN
        .byte_en   (be),
`endif
        .BusMuxIn  (BusMuxIn),
        .ready     (ready),
        .err       (err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] lanes);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    // Monitor: every ready pulse must match the oldest outstanding access.
    always @(negedge clock) begin
        if (ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("ready_unexpected", ready, 1'b0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ready_cycle", cyc, e.cyc);
                check("err", err, e.err);
                check("BusMuxIn", BusMuxIn, e.rdata);
            end
        end else if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
            check("ready_missing", ready, 1'b1);
            void'(exp_q.pop_front());
        end
    end

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 64) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("ready_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        @(negedge clock);
    endtask

    // One access; for hold > 1 the request lines keep toggling during BUSY
    // (as a write to a random address), which the DUT must ignore.
    task automatic access(input logic wr, input logic rd, input logic [ADDR_W-1:0] a,
                          input logic [31:0] d, input logic [3:0] b, input int hold);
        exp_t        e;
        logic        in_rng;
        logic [3:0]  lanes;
        @(negedge clock);
        write = wr; read = rd; addr = a; wdata = d; be = b;
`ifdef RAM_BYTE_MASK_EN
        lanes = b;
`else
        lanes = 4'hF;
`endif
        in_rng = (int'(a) < DEPTH);
        if (wr) begin
            if (in_rng) model_mem[int'(a)] = merge(model_mem[int'(a)], d, lanes);
        end else begin
            last_read = in_rng ? model_mem[int'(a)] : 32'h0;
        end
        e.cyc   = cyc + 2 + W;
        e.err   = !in_rng;
        e.rdata = last_read;
        exp_q.push_back(e);
        for (int i = 1; i < hold; i++) begin
            @(negedge clock);
            write = 1'b1; read = 1'($urandom);
            addr = ADDR_W'($urandom); wdata = $urandom;
        end
        @(negedge clock);
        write = 1'b0; read = 1'b0;
        wait_done();
    endtask

    // Write to a, then reset starting dly cycles after the accept edge for
    // len cycles; the write must be dropped and no ready issued.
    task automatic write_with_reset(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                                    input int dly, input int len);
        @(negedge clock);
        write = 1'b1; addr = a; wdata = d; be = 4'hF;
        @(negedge clock);
        write = 1'b0;
        repeat (dly) @(negedge clock);
        reset = 1'b1;
        repeat (len) @(negedge clock);
        reset = 1'b0;
        last_read = '0;
        check("rst_abort_BusMuxIn", BusMuxIn, 32'h0);
        check("rst_abort_err", err, 1'b0);
        check("rst_abort_ready", ready, 1'b0);
    endtask

    initial begin
        reset = 1'b1; read = 1'b0; write = 1'b0; addr = '0; wdata = '0; be = '0;
        repeat (2) @(negedge clock);
        check("rst_BusMuxIn", BusMuxIn, 32'h0);
        check("rst_ready", ready, 1'b0);
        check("rst_err", err, 1'b0);
        reset = 1'b0;

        // Fill the whole memory so the model knows every word.
        for (int a = 0; a < DEPTH; a++) access(1'b1, 1'b0, ADDR_W'(a), $urandom, 4'hF, 1);

        // Write then read; the read is held high into BUSY once.
        access(1'b1, 1'b0, 9'd5, 32'hDEADBEEF, 4'hF, 1);
        access(1'b0, 1'b1, 9'd5, 32'h0, 4'hF, 3);
        check("wr_rd_addr5", BusMuxIn, 32'hDEADBEEF);

        // Out of range: 300 >= DEPTH; addr 44 aliases it in the low bits.
        access(1'b1, 1'b0, 9'd300, 32'h12345678, 4'hF, 1);
        check("oor_write_err", err, 1'b1);
        access(1'b0, 1'b1, 9'd300, 32'h0, 4'hF, 1);
        check("oor_read_data", BusMuxIn, 32'h0);
        check("oor_read_err", err, 1'b1);
        access(1'b0, 1'b1, 9'd44, 32'h0, 4'hF, 1);
        access(1'b0, 1'b1, 9'd255, 32'h0, 4'hF, 1);
        access(1'b1, 1'b1, 9'd256, 32'h0BAD0BAD, 4'hF, 1);

        // Simultaneous read+write is a write; then read it back.
        access(1'b1, 1'b1, 9'd7, 32'hA5A5A5A5, 4'hF, 1);
        access(1'b0, 1'b1, 9'd7, 32'h0, 4'hF, 1);
        check("simul_write_addr7", BusMuxIn, 32'hA5A5A5A5);

        // Reset mid-access, and reset on the commit edge itself.
        write_with_reset(9'd9, 32'h01234567, 1, 2);
        access(1'b0, 1'b1, 9'd9, 32'h0, 4'hF, 1);
        write_with_reset(9'd10, 32'h89ABCDEF, W, 1);
        access(1'b0, 1'b1, 9'd10, 32'h0, 4'hF, 1);

`ifdef RAM_BYTE_MASK_EN
        access(1'b1, 1'b0, 9'd2, 32'hFFFFFFFF, 4'hF, 1);
        access(1'b1, 1'b0, 9'd2, 32'h00000000, 4'b0101, 1);
        access(1'b0, 1'b1, 9'd2, 32'h0, 4'hF, 1);
        check("byte_mask_read", BusMuxIn, 32'hFF00FF00);
        access(1'b1, 1'b0, 9'd2, 32'h12345678, 4'b0000, 1);
        access(1'b0, 1'b1, 9'd2, 32'h0, 4'hF, 1);
        check("byte_mask_none", BusMuxIn, 32'hFF00FF00);
`endif

        // Randomised traffic, mostly in range.
        for (int n = 0; n < 300; n++) begin
            logic              wr;
            logic [ADDR_W-1:0] a;
            wr = 1'($urandom);
            a  = ($urandom_range(0, 9) < 8) ? ADDR_W'($urandom_range(0, DEPTH - 1))
                                            : ADDR_W'($urandom);
            access(wr, wr ? 1'($urandom) : 1'b1, a, $urandom, 4'($urandom),
                   $urandom_range(1, W + 1));
        end

        repeat (5) @(negedge clock);
        check("idle_ready", ready, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
